// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory wait, redirect flush,
// fetch wait and sticky halt, with a saturating count of PC-frozen cycles.
module pipe_hazard_ctrl #(
    parameter int NSTAGE     = 4,
    parameter int REGW       = 5,
    parameter int LU_BUBBLES = 1,
    parameter int BR_STAGE   = 3,
    parameter int CNTW       = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              exmem_datarequest,
    input  logic              idex_DataRead,
    input  logic [REGW-1:0]   idex_rt,
    input  logic [REGW-1:0]   ifid_rs,
    input  logic [REGW-1:0]   ifid_rt,
    input  logic              npc_change,
    input  logic              idex_Halt,
    output logic              pc_WEN,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              halted,
    output logic [CNTW-1:0]   stall_count
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, HALTED} state_t;

    localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic              r_ret_lu;
    logic              r_redir_pend;
    logic [CNTW-1:0]   r_stall_count;

    state_t            w_next_state;
    logic [1:0]        w_next_cnt;
    logic              w_next_ret_lu;
    logic              w_next_pend;
    logic              w_pc_wen;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_flush;
    logic [NSTAGE-1:0] w_redir_mask;
    logic              w_load_use;
    logic              w_hold;

    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_mask
        assign w_redir_mask[gi] = (gi < BR_STAGE);
    end

    assign w_load_use = idex_DataRead && (idex_rt != '0) &&
                        ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Once parked in MEM_WAIT only dhit releases the pipe.
    assign w_hold = (r_state == MEM_WAIT) ? !dhit : (exmem_datarequest && !dhit);

    always_comb begin
        w_pc_wen      = 1'b1;
        w_stall       = '0;
        w_flush       = '0;
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_ret_lu = r_ret_lu;
        w_next_pend   = r_redir_pend;
        if (r_state == HALTED) begin
            w_pc_wen = 1'b0;
            w_stall  = '1;
        end else if (idex_Halt) begin
            w_pc_wen     = 1'b0;
            w_stall      = '1;
            w_next_state = HALTED;
            w_next_pend  = 1'b0;
        end else if (w_hold) begin
            // A redirect arriving while data is outstanding is deferred to the dhit cycle.
            w_pc_wen     = 1'b0;
            w_stall      = '1;
            w_next_state = MEM_WAIT;
            w_next_pend  = r_redir_pend | npc_change;
            if (r_state != MEM_WAIT) begin
                w_next_ret_lu = (r_state == LU_STALL);
            end
        end else if (npc_change || r_redir_pend) begin
            w_flush      = w_redir_mask;
            w_next_state = RUN;
            w_next_cnt   = '0;
            w_next_pend  = 1'b0;
        end else if (r_state == MEM_WAIT) begin
            w_next_state = r_ret_lu ? LU_STALL : RUN;
        end else if ((r_state == LU_STALL) || w_load_use) begin
            w_pc_wen   = 1'b0;
            w_stall[0] = 1'b1;
            w_flush[1] = 1'b1;
            if (r_state == LU_STALL) begin
                if (r_cnt <= 2'd1) begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - 2'd1;
                end
            end else begin
                w_next_state = (LU_BUBBLES == 1) ? RUN : LU_STALL;
                w_next_cnt   = LU_INIT;
            end
        end else if (!ihit) begin
            w_pc_wen   = 1'b0;
            w_flush[0] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= RUN;
            r_cnt         <= '0;
            r_ret_lu      <= 1'b0;
            r_redir_pend  <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_ret_lu     <= w_next_ret_lu;
            r_redir_pend <= w_next_pend;
            if (!w_pc_wen && (r_state != HALTED) && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    // Reset forces the bubble pattern on the outputs without waiting for a clock.
    assign pc_WEN      = nRST && w_pc_wen;
    assign stall       = nRST ? w_stall : '0;
    assign flush       = nRST ? w_flush : '1;
    assign halted      = (r_state == HALTED);
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, corner-case sequences and a
// randomized run against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int NS  = 4;
    localparam int RW  = 5;
    localparam int LUB = 2;
    localparam int BRS = 3;
    localparam int CW  = 4;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          ihit, dhit, dreq, dr, npc, halt;
    logic [RW-1:0] ex_rt, rs, rt;
    logic          pc_WEN;
    logic [NS-1:0] stall, flush;
    logic          halted;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int failures = 0;

    bit m_halted, m_in_mem, m_pend;
    int m_bub, m_cnt;

    typedef struct {
        logic ih, dh, dq, d_r;
        logic [RW-1:0] e, s, t;
        logic n, hl;
        logic p;
        logic [3:0] st, fl;
    } vec_t;
    vec_t tbl[16];

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.NSTAGE(NS), .REGW(RW), .LU_BUBBLES(LUB), .BR_STAGE(BRS), .CNTW(CW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_datarequest(dreq),
        .idex_DataRead(dr), .idex_rt(ex_rt), .ifid_rs(rs), .ifid_rt(rt),
        .npc_change(npc), .idex_Halt(halt), .pc_WEN(pc_WEN), .stall(stall),
        .flush(flush), .halted(halted), .stall_count(stall_count)
    );

    function automatic logic [13:0] ev(logic p, logic [3:0] s, logic [3:0] f, logic h, logic [3:0] c);
        return {p, s, f, h, c};
    endfunction

    function automatic logic [13:0] outs();
        return {pc_WEN, stall, flush, halted, stall_count};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp, input bit quiet);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got pc=%b stall=%b flush=%b halted=%b cnt=%0d, want pc=%b stall=%b flush=%b halted=%b cnt=%0d",
                     name, act[13], act[12:9], act[8:5], act[4], act[3:0],
                     exp[13], exp[12:9], exp[8:5], exp[4], exp[3:0]);
        end else if (!quiet) begin
            $display("ok   %s: pc=%b stall=%b flush=%b halted=%b cnt=%0d",
                     name, act[13], act[12:9], act[8:5], act[4], act[3:0]);
        end
    endtask

    task automatic drive(input logic ih, input logic dh, input logic dq, input logic d_r,
                         input logic [RW-1:0] e, input logic [RW-1:0] s, input logic [RW-1:0] t,
                         input logic n, input logic hl);
        ihit = ih; dhit = dh; dreq = dq; dr = d_r;
        ex_rt = e; rs = s; rt = t; npc = n; halt = hl;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        m_halted = 1'b0; m_in_mem = 1'b0; m_pend = 1'b0; m_bub = 0; m_cnt = 0;
    endtask

    // Rule-level model: priority halt > redirect/memory wait > load-use > fetch wait.
    task automatic model_cycle(output logic [13:0] exp);
        logic p;
        logic [3:0] s, f;
        bit lu, hold, was_halted;
        int cnt_now;
        p = 1'b1; s = 4'h0; f = 4'h0;
        was_halted = m_halted;
        cnt_now = m_cnt;
        lu = dr && (ex_rt != 0) && ((ex_rt == rs) || (ex_rt == rt));
        hold = m_in_mem ? !dhit : (dreq && !dhit);
        if (m_halted) begin
            p = 1'b0; s = 4'hF;
        end else if (halt) begin
            p = 1'b0; s = 4'hF; m_halted = 1'b1;
        end else if (hold) begin
            p = 1'b0; s = 4'hF; m_in_mem = 1'b1; m_pend = m_pend | npc;
        end else if (npc || m_pend) begin
            f = 4'((1 << BRS) - 1); m_bub = 0; m_in_mem = 1'b0; m_pend = 1'b0;
        end else if (m_in_mem) begin
            m_in_mem = 1'b0;
        end else if (m_bub > 0 || lu) begin
            p = 1'b0; s = 4'b0001; f = 4'b0010;
            m_bub = (m_bub > 0) ? m_bub - 1 : LUB - 1;
        end else if (!ihit) begin
            p = 1'b0; f = 4'b0001;
        end
        if (!was_halted && !p && m_cnt < (1 << CW) - 1) m_cnt++;
        exp = ev(p, s, f, was_halted, 4'(cnt_now));
    endtask

    initial begin
        logic [13:0] exp;
        idle();
        #2;
        check("reset_state", outs(), ev(1'b0, 4'h0, 4'hF, 1'b0, 4'd0), 1'b0);

        //              ih    dh    dq    dr    e     s     t     n     hl   | p    stall    flush
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0111};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0111};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};

        for (int i = 0; i < 16; i++) begin
            do_reset();
            drive(tbl[i].ih, tbl[i].dh, tbl[i].dq, tbl[i].d_r, tbl[i].e, tbl[i].s, tbl[i].t, tbl[i].n, tbl[i].hl);
            #3;
            check($sformatf("vec%0d", i), outs(), ev(tbl[i].p, tbl[i].st, tbl[i].fl, 1'b0, 4'd0), 1'b0);
            step();
        end

        // Load-use with two bubbles, then back to RUN.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); #3;
        check("lu_bubble0", outs(), ev(1'b0, 4'b0001, 4'b0010, 1'b0, 4'd0), 1'b0); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0); #3;
        check("lu_bubble1", outs(), ev(1'b0, 4'b0001, 4'b0010, 1'b0, 4'd1), 1'b0); step();
        #3;
        check("lu_done", outs(), ev(1'b1, 4'b0000, 4'b0000, 1'b0, 4'd2), 1'b0); step();
        #3;
        check("lu_cnt_hold", outs(), ev(1'b1, 4'b0000, 4'b0000, 1'b0, 4'd2), 1'b0); step();

        // Memory wait with a redirect arriving mid-wait.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, (c == 1), 1'b0); #3;
            check($sformatf("memwait_c%0d", c), outs(), ev(1'b0, 4'hF, 4'h0, 1'b0, 4'(c)), 1'b0); step();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #3;
        check("memwait_dhit", outs(), ev(1'b1, 4'h0, 4'b0111, 1'b0, 4'd3), 1'b0); step();
        idle(); #3;
        check("memwait_after", outs(), ev(1'b1, 4'h0, 4'h0, 1'b0, 4'd3), 1'b0); step();

        // Halt is sticky and ignores redirect; counter freezes.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); #3;
        check("halt_req", outs(), ev(1'b0, 4'hF, 4'h0, 1'b0, 4'd0), 1'b0); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); #3;
        check("halt_npc", outs(), ev(1'b0, 4'hF, 4'h0, 1'b1, 4'd1), 1'b0); step();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0); #3;
            check($sformatf("halt_sticky%0d", c), outs(), ev(1'b0, 4'hF, 4'h0, 1'b1, 4'd1), 1'b0); step();
        end

        // Fetch wait long enough to saturate the counter.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #3;
            check($sformatf("sat_c%0d", c), outs(), ev(1'b0, 4'h0, 4'b0001, 1'b0, 4'((c > 15) ? 15 : c)), 1'b0);
            step();
        end
        idle(); #3;
        check("sat_final", outs(), ev(1'b1, 4'h0, 4'h0, 1'b0, 4'd15), 1'b0); step();

        // Asynchronous reset in the middle of MEM_WAIT and of LU_STALL.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step(); #3;
        check("rst_mw_pre", outs(), ev(1'b0, 4'hF, 4'h0, 1'b0, 4'd1), 1'b0);
        nRST = 1'b0; #1;
        check("rst_mw_async", outs(), ev(1'b0, 4'h0, 4'hF, 1'b0, 4'd0), 1'b0);
        step();
        idle(); nRST = 1'b1; #3;
        check("rst_mw_release", outs(), ev(1'b1, 4'h0, 4'h0, 1'b0, 4'd0), 1'b0); step(); #3;
        check("rst_mw_run", outs(), ev(1'b1, 4'h0, 4'h0, 1'b0, 4'd0), 1'b0); step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd2, 1'b0, 1'b0); step();
        idle(); #3;
        check("rst_lu_pre", outs(), ev(1'b0, 4'b0001, 4'b0010, 1'b0, 4'd1), 1'b0);
        nRST = 1'b0; #1;
        check("rst_lu_async", outs(), ev(1'b0, 4'h0, 4'hF, 1'b0, 4'd0), 1'b0);
        step();
        nRST = 1'b1; step(); #3;
        check("rst_lu_run", outs(), ev(1'b1, 4'h0, 4'h0, 1'b0, 4'd0), 1'b0); step();

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            ihit  = ($urandom_range(0, 3) != 0);
            dhit  = ($urandom_range(0, 3) != 0);
            dreq  = ($urandom_range(0, 2) == 0);
            dr    = ($urandom_range(0, 1) == 1);
            ex_rt = 5'($urandom_range(0, 3));
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            npc   = ($urandom_range(0, 7) == 0);
            halt  = ($urandom_range(0, 79) == 0);
            #3;
            model_cycle(exp);
            check($sformatf("rnd%0d", i), outs(), exp, 1'b1);
            check($sformatf("rnd%0d_disjoint", i), 14'(stall & flush), 14'd0, 1'b1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
